// File: rtl/conveyor_writeback_arbiter_if.sv
// Bundle between the result producers, the writeback arbiter and the conveyor slot write port.
// The arbiter takes the slave modport. Producers and the core side take the master modport.
interface conveyor_writeback_arbiter_if #(
    parameter int WORD_WIDTH          = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    parameter int NUM_REQ             = 4
);
    localparam int FAULT_ADDR_WIDTH = 3;
    localparam int CONVEYOR_WIDTH   = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH;

    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ-1:0][CONVEYOR_ADDR_WIDTH-1:0] req_slot;
    logic [NUM_REQ-1:0][WORD_WIDTH-1:0]          req_value;
    logic [NUM_REQ-1:0][FAULT_ADDR_WIDTH-1:0]    req_fault;
    logic [NUM_REQ-1:0]                          req_grant;
    logic                                        wr_stall;
    logic                                        wr_en;
    logic [CONVEYOR_ADDR_WIDTH-1:0]              wr_addr;
    logic [CONVEYOR_WIDTH-1:0]                   wr_data;

    modport master (
        output req_valid, req_slot, req_value, req_fault, wr_stall,
        input  req_grant, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_slot, req_value, req_fault, wr_stall,
        output req_grant, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conveyor_writeback_arbiter.sv
// Round-robin arbiter sharing the single conveyor slot write port among NUM_REQ producers.
// Optional macro CONVEYOR_WB_FAULT_PRIORITY_EN lets faulting requests win over clean ones.
module conveyor_writeback_arbiter #(
    parameter int WORD_WIDTH          = 32,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    parameter int NUM_REQ             = 4
) (
    input logic                         clk,
    input logic                         reset,
    conveyor_writeback_arbiter_if.slave bus
);
    localparam int FAULT_ADDR_WIDTH = 3;
    localparam int CONVEYOR_WIDTH   = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH;
    localparam int PTR_W            = $clog2(NUM_REQ);

    typedef enum logic {
        ENTRY_EMPTY = 1'b0,
        ENTRY_FULL  = 1'b1
    } entry_state_t;

    entry_state_t                   entry_state;
    logic [PTR_W-1:0]               rr_ptr;
    logic [CONVEYOR_ADDR_WIDTH-1:0] wr_addr_q;
    logic [CONVEYOR_WIDTH-1:0]      wr_data_q;

    logic                           output_free;
    logic [NUM_REQ-1:0]             eligible;
    logic                           grant_found;
    logic [PTR_W-1:0]               grant_idx;
    logic [PTR_W-1:0]               rr_next;
    logic [PTR_W:0]                 cand;
    logic [NUM_REQ-1:0]             req_grant_c;

`ifdef CONVEYOR_WB_FAULT_PRIORITY_EN
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_NONE = '0;
    logic [NUM_REQ-1:0] fault_mask;
`endif

    assign output_free = (entry_state == ENTRY_EMPTY) || !bus.wr_stall;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_grant_c = '0;
`ifdef CONVEYOR_WB_FAULT_PRIORITY_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            fault_mask[i] = bus.req_valid[i] && (bus.req_fault[i] != F_NONE);
        end
        eligible = (|fault_mask) ? fault_mask : bus.req_valid;
`else
        eligible = bus.req_valid;
`endif
        // Search upward from rr_ptr with wrap; the first eligible index wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
        if (grant_found && output_free && !reset) begin
            req_grant_c = NUM_REQ'(1) << grant_idx;
        end
    end

    assign rr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_state <= ENTRY_EMPTY;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rr_ptr      <= '0;
        end else if (output_free) begin
            if (grant_found) begin
                entry_state <= ENTRY_FULL;
                wr_addr_q   <= bus.req_slot[grant_idx];
                wr_data_q   <= {1'b1, bus.req_fault[grant_idx], bus.req_value[grant_idx]};
                rr_ptr      <= rr_next;
            end else begin
                entry_state <= ENTRY_EMPTY;
            end
        end
    end

    assign bus.req_grant = req_grant_c;
    assign bus.wr_en     = (entry_state == ENTRY_FULL);
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_conveyor_writeback_arbiter.sv
// Directed scoreboard bench for conveyor_writeback_arbiter; expected slot writes are queued
// at grant time and checked by an independent output monitor.
module tb_conveyor_writeback_arbiter;
    localparam int WORD_WIDTH          = 32;
    localparam int CONVEYOR_ADDR_WIDTH = 4;
    localparam int NUM_REQ             = 4;
    localparam int CONVEYOR_WIDTH      = 1 + 3 + WORD_WIDTH;

    typedef struct packed {
        logic [CONVEYOR_ADDR_WIDTH-1:0] addr;
        logic [CONVEYOR_WIDTH-1:0]      data;
    } wr_entry_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wr_entry_t                      sb[$];
    logic [CONVEYOR_ADDR_WIDTH-1:0] slot_tab  [NUM_REQ];
    logic [WORD_WIDTH-1:0]          value_tab [NUM_REQ];
    logic [2:0]                     fault_tab [NUM_REQ];

    conveyor_writeback_arbiter_if #(
        .WORD_WIDTH(WORD_WIDTH),
        .CONVEYOR_ADDR_WIDTH(CONVEYOR_ADDR_WIDTH),
        .NUM_REQ(NUM_REQ)
    ) bus ();

    conveyor_writeback_arbiter #(
        .WORD_WIDTH(WORD_WIDTH),
        .CONVEYOR_ADDR_WIDTH(CONVEYOR_ADDR_WIDTH),
        .NUM_REQ(NUM_REQ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [CONVEYOR_ADDR_WIDTH-1:0] slot,
                           input logic [WORD_WIDTH-1:0] value, input logic [2:0] fault);
        slot_tab[i]       = slot;
        value_tab[i]      = value;
        fault_tab[i]      = fault;
        bus.req_slot[i]   = slot;
        bus.req_value[i]  = value;
        bus.req_fault[i]  = fault;
    endtask

    // One cycle: drive inputs after the edge, check grant and wr_en at the falling edge,
    // and queue the slot write that the granted requester should produce.
    task automatic apply_stimulus(input logic [NUM_REQ-1:0] valid, input logic stall,
                                  input logic [NUM_REQ-1:0] exp_grant, input logic exp_wr_en,
                                  input string name);
        int g;
        bus.req_valid = valid;
        bus.wr_stall  = stall;
        @(negedge clk);
        check_output({name, "_grant"}, 64'(bus.req_grant), 64'(exp_grant));
        check_output({name, "_wr_en"}, 64'(bus.wr_en), 64'(exp_wr_en));
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_grant[i]) g = i;
        end
        if (g >= 0) begin
            sb.push_back('{addr: slot_tab[g], data: {1'b1, fault_tab[g], value_tab[g]}});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.wr_stall  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.wr_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got wr_en=1 addr=%0h expected no write at %0t",
                             bus.wr_addr, $time);
                end else begin
                    check_output("wr_addr", 64'(bus.wr_addr), 64'(sb[0].addr));
                    check_output("wr_data", 64'(bus.wr_data), 64'(sb[0].data));
                    if (!bus.wr_stall) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, '0);
        reset         = 1'b1;
        bus.wr_stall  = 1'b0;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        check_output("reset_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("reset_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_output("reset_wr_data", 64'(bus.wr_data), 64'd0);
        check_output("reset_grant", 64'(bus.req_grant), 64'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single request");
        set_req(0, 4'd5, 32'hDEADBEEF, 3'd0);
        apply_stimulus(4'b0001, 1'b0, 4'b0001, 1'b0, "single_c0");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1, "single_c1");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "single_c2");

        $display("[TB] fairness");
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i + 1), 32'h1000_0000 + 32'(i), 3'd0);
        apply_stimulus(4'b1111, 1'b0, 4'b0001, 1'b0, "fair_0");
        apply_stimulus(4'b1111, 1'b0, 4'b0010, 1'b1, "fair_1");
        apply_stimulus(4'b1111, 1'b0, 4'b0100, 1'b1, "fair_2");
        apply_stimulus(4'b1111, 1'b0, 4'b1000, 1'b1, "fair_3");
        apply_stimulus(4'b1111, 1'b0, 4'b0001, 1'b1, "fair_4");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1, "fair_drain");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "fair_idle");

        $display("[TB] stall");
        do_reset();
        set_req(0, 4'd4, 32'h0000_0404, 3'd0);
        set_req(2, 4'd9, 32'h0000_0909, 3'd1);
        apply_stimulus(4'b0100, 1'b0, 4'b0100, 1'b0, "stall_grant");
        apply_stimulus(4'b0001, 1'b1, 4'b0000, 1'b1, "stall_1");
        apply_stimulus(4'b0001, 1'b1, 4'b0000, 1'b1, "stall_2");
        apply_stimulus(4'b0001, 1'b1, 4'b0000, 1'b1, "stall_3");
        apply_stimulus(4'b0001, 1'b0, 4'b0001, 1'b1, "stall_resume");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1, "stall_drain");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "stall_idle");

        $display("[TB] wrap");
        do_reset();
        set_req(0, 4'd1, 32'hAAAA_0000, 3'd0);
        set_req(2, 4'd2, 32'hCCCC_0000, 3'd0);
        set_req(3, 4'd14, 32'hDDDD_0000, 3'd0);
        apply_stimulus(4'b0100, 1'b0, 4'b0100, 1'b0, "wrap_setup");
        apply_stimulus(4'b1001, 1'b0, 4'b1000, 1'b1, "wrap_0");
        apply_stimulus(4'b1001, 1'b0, 4'b0001, 1'b1, "wrap_1");
        apply_stimulus(4'b1001, 1'b0, 4'b1000, 1'b1, "wrap_2");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1, "wrap_drain");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "wrap_idle");

        $display("[TB] reset mid-stall");
        do_reset();
        set_req(1, 4'd12, 32'hCAFE_0001, 3'd0);
        set_req(3, 4'd7, 32'h0000_0033, 3'd2);
        apply_stimulus(4'b0010, 1'b0, 4'b0010, 1'b0, "rst_grant");
        apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b1, "rst_held_1");
        apply_stimulus(4'b0000, 1'b1, 4'b0000, 1'b1, "rst_held_2");
        reset         = 1'b1;
        bus.req_valid = 4'b1010;
        sb.delete();
        #2;
        check_output("rst_async_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("rst_async_grant", 64'(bus.req_grant), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rst_hold_wr_en", 64'(bus.wr_en), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(4'b1010, 1'b0, 4'b0010, 1'b0, "rst_regrant");
        apply_stimulus(4'b1000, 1'b0, 4'b1000, 1'b1, "rst_next");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1, "rst_drain");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "rst_idle");

        $display("[TB] fault class and same slot");
        do_reset();
        set_req(0, 4'd3, 32'hA0A0_A0A0, 3'd0);
        set_req(1, 4'd3, 32'hB1B1_B1B1, 3'd3);
`ifdef CONVEYOR_WB_FAULT_PRIORITY_EN
        apply_stimulus(4'b0011, 1'b0, 4'b0010, 1'b0, "fault_first");
        apply_stimulus(4'b0001, 1'b0, 4'b0001, 1'b1, "fault_second");
`else
        apply_stimulus(4'b0011, 1'b0, 4'b0001, 1'b0, "fault_first");
        apply_stimulus(4'b0010, 1'b0, 4'b0010, 1'b1, "fault_second");
`endif
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b1, "fault_drain");
        apply_stimulus(4'b0000, 1'b0, 4'b0000, 1'b0, "fault_idle");

        repeat (3) @(posedge clk);
        #1;
        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
